// File: rtl/aes_round_iter.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly
// key expansion. NUM_ROUNDS selects how many rounds follow the initial
// AddRoundKey (10 = full FIPS-197 AES). The live state can be tapped out
// for fault-injection and side-channel work.

// Combinational AES S-box lane: one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module aes_round_iter #(
  parameter int NUM_ROUNDS = 10,
  parameter bit TAP_EN     = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plain_txt,
  input  logic [127:0] masterkey,
  output logic         busy,
  output logic         done,
  output logic [127:0] cipher_out,
  output logic [127:0] round_out,
  output logic [3:0]   round_idx
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
    $error("aes_round_iter: NUM_ROUNDS must be in 1..10");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e       fsm_q, fsm_d;
  logic         load, step;
  logic [127:0] st_q, rk_q;
  logic [3:0]   ridx_q;
  logic [3:0]   rnd;
  logic         last;

  // GF(2^8) multiply by 2; result stays 8 bits.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round being computed this cycle and whether it finishes the block.
  assign rnd  = ridx_q + 4'd1;
  assign last = (rnd == LAST_RND);

  // ---------------- round datapath ----------------
  // sr[i] / mc[i] hold state byte i (byte 0 = bits [127:120]), column-major.
  logic [15:0][7:0] sr, mc;
  logic [127:0]     sr_w, mc_w, nxt_st;

  // SubBytes with ShiftRows folded into the lane input selection:
  // output (row r, col c) takes input (row r, col c+r mod 4).
  for (genvar i = 0; i < 16; i++) begin : g_sub
    localparam int R   = i % 4;
    localparam int C   = i / 4;
    localparam int SRC = 4 * ((C + R) % 4) + R;
    aes_sbox u_sbox (.a(st_q[127-8*SRC -: 8]), .y(sr[i]));
    assign sr_w[127-8*i -: 8] = sr[i];
    assign mc_w[127-8*i -: 8] = mc[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  // ---------------- key schedule ----------------
  logic [31:0]  w0, w1, w2, w3, rot, sw, tmp;
  logic [127:0] nxt_key;

  assign w0  = rk_q[127:96];
  assign w1  = rk_q[95:64];
  assign w2  = rk_q[63:32];
  assign w3  = rk_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksub
    aes_sbox u_sbox (.a(rot[31-8*j -: 8]), .y(sw[31-8*j -: 8]));
  end

  assign tmp = sw ^ {rcon(rnd), 24'h0};
  assign nxt_key[127:96] = w0 ^ tmp;
  assign nxt_key[95:64]  = w1 ^ nxt_key[127:96];
  assign nxt_key[63:32]  = w2 ^ nxt_key[95:64];
  assign nxt_key[31:0]   = w3 ^ nxt_key[63:32];

  // The final round of full AES drops MixColumns.
  assign nxt_st = ((rnd == 4'd10) ? sr_w : mc_w) ^ nxt_key;

  // ---------------- control ----------------
  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next state plus load/step strobes; start is only honoured when not busy.
  always_comb begin
    fsm_d = fsm_q;
    load  = 1'b0;
    step  = 1'b0;
    unique case (fsm_q)
      S_IDLE: if (start) begin
        load  = 1'b1;
        fsm_d = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (last) fsm_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          load  = 1'b1;
          fsm_d = S_RUN;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State/key registers, round counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= '0;
      rk_q       <= '0;
      ridx_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cipher_out <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        st_q   <= plain_txt ^ masterkey;
        rk_q   <= masterkey;
        ridx_q <= '0;
        busy   <= 1'b1;
      end else if (step) begin
        st_q   <= nxt_st;
        rk_q   <= nxt_key;
        ridx_q <= rnd;
        if (last) begin
          cipher_out <= nxt_st;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
      end
    end
  end

  // Observation taps.
  if (TAP_EN) begin : g_tap
    assign round_out = st_q;
    assign round_idx = ridx_q;
  end else begin : g_notap
    assign round_out = '0;
    assign round_idx = '0;
  end

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed bench for aes_round_iter: full AES (NUM_ROUNDS=10) and the
// single-round build (NUM_ROUNDS=1) against FIPS-197 vectors.
module tb_aes_round_iter;

  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ARKB = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ARKC = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         start1 = 1'b0;
  logic [127:0] pt = '0;
  logic [127:0] key = '0;

  logic         busy, done, busy1, done1;
  logic [127:0] cipher, rout, cipher1, rout1;
  logic [3:0]   ridx, ridx1;

  int tests = 0;
  int fails = 0;

  aes_round_iter #(.NUM_ROUNDS(10), .TAP_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .plain_txt(pt), .masterkey(key),
    .busy(busy), .done(done), .cipher_out(cipher), .round_out(rout), .round_idx(ridx)
  );

  aes_round_iter #(.NUM_ROUNDS(1), .TAP_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .plain_txt(pt), .masterkey(key),
    .busy(busy1), .done(done1), .cipher_out(cipher1), .round_out(rout1), .round_idx(ridx1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_cipher", cipher, '0);
    chk("rst_round_out", rout, '0);
    chk("rst_round_idx", 128'(ridx), 128'd0);
    chk("rst_busy1", 128'(busy1), 128'd0);
    reset = 1'b0;
    tick();

    // single-round build
    pt = PB; key = KB; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("r1_ark", rout1, ARKB);
    chk("r1_busy", 128'(busy1), 128'd1);
    chk("r1_done_early", 128'(done1), 128'd0);
    tick();
    chk("r1_done", 128'(done1), 128'd1);
    chk("r1_cipher", cipher1, R1B);
    chk("r1_busy_off", 128'(busy1), 128'd0);
    chk("r1_idx", 128'(ridx1), 128'd1);
    tick();
    chk("r1_done_pulse", 128'(done1), 128'd0);
    chk("r1_hold", cipher1, R1B);

    // full AES, App. B
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_ark", rout, ARKB);
    chk("b_busy", 128'(busy), 128'd1);
    chk("b_idx0", 128'(ridx), 128'd0);
    tick();
    chk("b_round1", rout, R1B);
    chk("b_idx1", 128'(ridx), 128'd1);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("b_no_done", 128'(done), 128'd0);
      chk("b_idx", 128'(ridx), 128'(k));
    end
    tick();
    chk("b_done", 128'(done), 128'd1);
    chk("b_busy_off", 128'(busy), 128'd0);
    chk("b_cipher", cipher, CB);
    chk("b_idx10", 128'(ridx), 128'd10);

    // back-to-back App. C.1, start during the DONE cycle
    pt = PC; key = KC; start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_busy", 128'(busy), 128'd1);
    chk("c_done_pulse", 128'(done), 128'd0);
    chk("c_ark", rout, ARKC);
    chk("c_hold0", cipher, CB);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("c_hold", cipher, CB);
      chk("c_no_done", 128'(done), 128'd0);
    end
    tick();
    chk("c_done", 128'(done), 128'd1);
    chk("c_cipher", cipher, CC);
    tick();
    chk("c_done_pulse2", 128'(done), 128'd0);
    chk("c_idle_busy", 128'(busy), 128'd0);
    tick(); tick(); tick();
    chk("c_hold_idle", cipher, CC);

    // inputs change right after the start edge
    pt = PB; key = KB; start = 1'b1;
    tick();
    start = 1'b0;
    pt = ~PB; key = KC;
    for (int k = 1; k <= 9; k++) tick();
    chk("chg_no_done", 128'(done), 128'd0);
    tick();
    chk("chg_done", 128'(done), 128'd1);
    chk("chg_cipher", cipher, CB);
    tick();

    // reset mid-operation
    pt = PB; key = KB; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("rm_idx6", 128'(ridx), 128'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", 128'(busy), 128'd0);
    chk("rm_done", 128'(done), 128'd0);
    chk("rm_cipher", cipher, '0);
    chk("rm_idx", 128'(ridx), 128'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("rm_no_done", 128'({busy, done}), 128'd0);
    end
    pt = PC; key = KC; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    tick();
    chk("rm_re_done", 128'(done), 128'd1);
    chk("rm_re_cipher", cipher, CC);
    tick();

    // start ignored while busy
    pt = PB; key = KB; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("ign_idx4", 128'(ridx), 128'd4);
    pt = PC; key = KC; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 128'(busy), 128'd1);
    chk("ign_idx5", 128'(ridx), 128'd5);
    for (int k = 6; k <= 9; k++) begin
      tick();
      chk("ign_run", 128'({busy, done}), 128'b10);
    end
    tick();
    chk("ign_done", 128'(done), 128'd1);
    chk("ign_busy_off", 128'(busy), 128'd0);
    chk("ign_cipher", cipher, CB);
    tick();
    chk("ign_idle", 128'({busy, done}), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
